vram_access_arbiter: RTL and testbench

//  Shares one single-port synchronous video RAM between display fetch (character/pixel reads driven by the

---
 rtl/vram_arb_pkg.sv | 19 +
 rtl/vram_access_arbiter_fifo.sv | 59 +++++
 rtl/vram_access_arbiter.sv | 135 +++++++++++++
 tb/tb_vram_access_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// Shared encodings for the VRAM access arbiter: grant states, read source tags
// and the fixed RAM read latency.
package vram_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DISP = 2'd1,
        S_HOST = 2'd2
    } grant_state_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_HOST = 2'd2
    } src_tag_t;

    localparam int unsigned VRAM_RD_LATENCY = 2;

endpackage

// File: rtl/vram_access_arbiter_fifo.sv
// Host request FIFO for the VRAM arbiter: synchronous, show-ahead head entry,
// asynchronous active-low reset. DEPTH must be a power of two, >= 2.
module vram_req_fifo #(
    parameter int unsigned WIDTH = 21,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/vram_access_arbiter.sv
// Single-port VRAM arbiter: display reads have absolute priority, host requests queue in a FIFO.
// Optional `VRAM_BLANK_WRITE_EN restricts host writes at the FIFO head to blanking intervals.
module vram_access_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          pixel_clock,
    input  logic                          reset_n,
    input  logic                          blank,
    input  logic                          disp_req,
    input  logic [ADDR_W-1:0]             disp_addr,
    output logic                          disp_rvalid,
    output logic [DATA_W-1:0]             disp_rdata,
    input  logic                          host_valid,
    output logic                          host_ready,
    input  logic                          host_we,
    input  logic [ADDR_W-1:0]             host_addr,
    input  logic [DATA_W-1:0]             host_wdata,
    output logic                          host_rvalid,
    output logic [DATA_W-1:0]             host_rdata,
    output logic                          ram_en,
    output logic                          ram_we,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [DATA_W-1:0]             ram_wdata,
    input  logic [DATA_W-1:0]             ram_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   stall_count
);

    localparam int unsigned ENTRY_W = 1 + ADDR_W + DATA_W;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_din;
    logic [ENTRY_W-1:0] fifo_head;
    logic               head_we;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_wdata;
    logic               host_eligible;

    grant_state_t       state;
    grant_state_t       grant_next;
    src_tag_t           tag_in;
    src_tag_t           tag_pipe [VRAM_RD_LATENCY];
    logic               ram_we_next;
    logic [ADDR_W-1:0]  ram_addr_next;
    logic [DATA_W-1:0]  ram_wdata_next;

    assign fifo_din                          = {host_we, host_addr, host_wdata};
    assign {head_we, head_addr, head_wdata}  = fifo_head;
    assign host_ready                        = !fifo_full;
    assign fifo_push                         = host_valid && !fifo_full;
    assign fifo_pop                          = (grant_next == S_HOST);

    vram_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (pixel_clock),
        .rst_n (reset_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

`ifdef VRAM_BLANK_WRITE_EN
    // A write held at the head also blocks every entry behind it, keeping FIFO order.
    assign host_eligible = !head_we || blank;
`else
    logic blank_unused;
    assign blank_unused  = blank;
    assign host_eligible = 1'b1;
`endif

    always_comb begin
        grant_next     = S_IDLE;
        tag_in         = TAG_NONE;
        ram_we_next    = 1'b0;
        ram_addr_next  = '0;
        ram_wdata_next = '0;
        if (disp_req) begin
            grant_next    = S_DISP;
            tag_in        = TAG_DISP;
            ram_addr_next = disp_addr;
        end else if (!fifo_empty && host_eligible) begin
            grant_next     = S_HOST;
            tag_in         = head_we ? TAG_NONE : TAG_HOST;
            ram_we_next    = head_we;
            ram_addr_next  = head_addr;
            ram_wdata_next = head_we ? head_wdata : '0;
        end
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            stall_count <= '0;
            for (int unsigned i = 0; i < VRAM_RD_LATENCY; i++) begin
                tag_pipe[i] <= TAG_NONE;
            end
        end else begin
            state     <= grant_next;
            ram_we    <= ram_we_next;
            ram_addr  <= ram_addr_next;
            ram_wdata <= ram_wdata_next;
            tag_pipe[0] <= tag_in;
            for (int unsigned i = 1; i < VRAM_RD_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            if (!fifo_empty && (grant_next != S_HOST) && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

    // The registered state is the current RAM owner, so the strobe follows it directly.
    assign ram_en      = (state != S_IDLE);
    assign disp_rvalid = (tag_pipe[VRAM_RD_LATENCY-1] == TAG_DISP);
    assign host_rvalid = (tag_pipe[VRAM_RD_LATENCY-1] == TAG_HOST);
    assign disp_rdata  = disp_rvalid ? ram_rdata : '0;
    assign host_rdata  = host_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_vram_access_arbiter.sv
// Directed bench for vram_access_arbiter with a behavioural single-port RAM attached.
module tb_vram_access_arbiter;

    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FIFO_DEPTH = 4;

    logic               pixel_clock = 1'b0;
    logic               reset_n     = 1'b0;
    logic               blank       = 1'b1;
    logic               disp_req    = 1'b0;
    logic [ADDR_W-1:0]  disp_addr   = '0;
    logic               disp_rvalid;
    logic [DATA_W-1:0]  disp_rdata;
    logic               host_valid  = 1'b0;
    logic               host_ready;
    logic               host_we     = 1'b0;
    logic [ADDR_W-1:0]  host_addr   = '0;
    logic [DATA_W-1:0]  host_wdata  = '0;
    logic               host_rvalid;
    logic [DATA_W-1:0]  host_rdata;
    logic               ram_en;
    logic               ram_we;
    logic [ADDR_W-1:0]  ram_addr;
    logic [DATA_W-1:0]  ram_wdata;
    logic [DATA_W-1:0]  ram_rdata;
    logic [2:0]         fifo_level;
    logic [15:0]        stall_count;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mem [4096];
    bit                written [4096];

    always #5 pixel_clock = ~pixel_clock;

    // Unwritten locations read back as addr[7:0]^0x3C so display data is predictable.
    always @(posedge pixel_clock) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr]     <= ram_wdata;
                written[ram_addr] <= 1'b1;
            end else begin
                ram_rdata <= written[ram_addr] ? mem[ram_addr] : (ram_addr[7:0] ^ 8'h3C);
            end
        end
    end

    vram_access_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .pixel_clock (pixel_clock),
        .reset_n     (reset_n),
        .blank       (blank),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_rvalid (disp_rvalid),
        .disp_rdata  (disp_rdata),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .fifo_level  (fifo_level),
        .stall_count (stall_count)
    );

    task automatic tick();
        @(posedge pixel_clock);
        #1;
    endtask

    task automatic idle_inputs();
        disp_req   = 1'b0;
        disp_addr  = '0;
        host_valid = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        checks++;
        if ({ram_en, ram_we, ram_addr, ram_wdata, disp_rvalid, disp_rdata,
             host_rvalid, host_rdata, fifo_level, stall_count} !== 59'd0) begin
            errors++;
            $display("FAIL reset_outputs got en=%0b we=%0b addr=%h wd=%h drv=%0b hrv=%0b lvl=%0d stall=%0d want all zero",
                     ram_en, ram_we, ram_addr, ram_wdata, disp_rvalid, host_rvalid, fifo_level, stall_count);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if ({host_ready, fifo_level} !== {1'b1, 3'd0}) begin
            errors++;
            $display("FAIL reset_release got ready=%0b lvl=%0d want ready=1 lvl=0", host_ready, fifo_level);
        end
    endtask

    task automatic test_write_read();
        host_valid = 1'b1; host_we = 1'b1; host_addr = 12'h010; host_wdata = 8'h5A;
        tick();
        host_valid = 1'b0;
        checks++;
        if ({ram_en, fifo_level} !== {1'b0, 3'd1}) begin
            errors++;
            $display("FAIL wr_queued got en=%0b lvl=%0d want en=0 lvl=1", ram_en, fifo_level);
        end
        tick();
        checks++;
        if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 12'h010, 8'h5A}) begin
            errors++;
            $display("FAIL wr_issue got en=%0b we=%0b addr=%h wd=%h want 1 1 010 5a", ram_en, ram_we, ram_addr, ram_wdata);
        end
        host_valid = 1'b1; host_we = 1'b0; host_addr = 12'h010; host_wdata = 8'h00;
        tick();
        host_valid = 1'b0;
        tick();
        checks++;
        if ({ram_en, ram_we, ram_addr, host_rvalid} !== {1'b1, 1'b0, 12'h010, 1'b0}) begin
            errors++;
            $display("FAIL rd_issue got en=%0b we=%0b addr=%h hrv=%0b want 1 0 010 0", ram_en, ram_we, ram_addr, host_rvalid);
        end
        tick();
        checks++;
        if ({host_rvalid, host_rdata, disp_rvalid} !== {1'b1, 8'h5A, 1'b0}) begin
            errors++;
            $display("FAIL rd_data got hrv=%0b hrd=%h drv=%0b want 1 5a 0", host_rvalid, host_rdata, disp_rvalid);
        end
        tick();
        checks++;
        if ({host_rvalid, ram_en} !== 2'b00) begin
            errors++;
            $display("FAIL rd_done got hrv=%0b en=%0b want 0 0", host_rvalid, ram_en);
        end
    endtask

    task automatic test_disp_priority();
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_data;
        logic              exp_valid;
        do_reset();
        host_valid = 1'b1; host_we = 1'b1; host_addr = 12'h200; host_wdata = 8'h11;
        tick();
        for (int k = 1; k <= 10; k++) begin
            disp_req   = 1'b1;
            disp_addr  = 12'(12'h100 + k);
            host_valid = (k <= 3);
            host_addr  = 12'(12'h200 + k);
            host_wdata = 8'(8'h11 * (k + 1));
            tick();
            checks++;
            if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 12'(12'h100 + k)}) begin
                errors++;
                $display("FAIL disp_grant k=%0d got en=%0b we=%0b addr=%h want 1 0 %h",
                         k, ram_en, ram_we, ram_addr, 12'(12'h100 + k));
            end
            exp_valid = (k >= 2);
            exp_addr  = 12'(12'h100 + k - 1);
            exp_data  = exp_valid ? (exp_addr[7:0] ^ 8'h3C) : 8'h00;
            checks++;
            if ({disp_rvalid, disp_rdata} !== {exp_valid, exp_data}) begin
                errors++;
                $display("FAIL disp_rdata k=%0d got rv=%0b rd=%h want rv=%0b rd=%h",
                         k, disp_rvalid, disp_rdata, exp_valid, exp_data);
            end
            if (k == 3) begin
                checks++;
                if ({host_ready, fifo_level} !== {1'b0, 3'd4}) begin
                    errors++;
                    $display("FAIL fifo_full got ready=%0b lvl=%0d want ready=0 lvl=4", host_ready, fifo_level);
                end
            end
        end
        host_valid = 1'b0;
        checks++;
        if (stall_count !== 16'd10) begin
            errors++;
            $display("FAIL stall_ten got %0d want 10", stall_count);
        end
    endtask

    task automatic test_drain();
        disp_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({ram_en, ram_we, ram_addr, ram_wdata, fifo_level} !==
                {1'b1, 1'b1, 12'(12'h200 + i), 8'(8'h11 * (i + 1)), 3'(3 - i)}) begin
                errors++;
                $display("FAIL drain i=%0d got en=%0b we=%0b addr=%h wd=%h lvl=%0d want 1 1 %h %h %0d",
                         i, ram_en, ram_we, ram_addr, ram_wdata, fifo_level,
                         12'(12'h200 + i), 8'(8'h11 * (i + 1)), 3 - i);
            end
            if (i == 0) begin
                checks++;
                if ({disp_rvalid, disp_rdata} !== {1'b1, 8'h0A ^ 8'h3C}) begin
                    errors++;
                    $display("FAIL disp_tail got rv=%0b rd=%h want 1 %h", disp_rvalid, disp_rdata, 8'h0A ^ 8'h3C);
                end
            end
        end
        tick();
        checks++;
        if ({ram_en, fifo_level, stall_count} !== {1'b0, 3'd0, 16'd10}) begin
            errors++;
            $display("FAIL drain_end got en=%0b lvl=%0d stall=%0d want 0 0 10", ram_en, fifo_level, stall_count);
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        disp_req = 1'b1;
        host_valid = 1'b1; host_we = 1'b1;
        host_addr = 12'h300; host_wdata = 8'hA0;
        tick();
        host_addr = 12'h301; host_wdata = 8'hA1;
        tick();
        checks++;
        if (fifo_level !== 3'd2) begin
            errors++;
            $display("FAIL pp_level_pre got %0d want 2", fifo_level);
        end
        disp_req = 1'b0;
        host_addr = 12'h302; host_wdata = 8'hA2;
        tick();
        host_valid = 1'b0;
        checks++;
        if ({fifo_level, ram_en, ram_addr, ram_wdata} !== {3'd2, 1'b1, 12'h300, 8'hA0}) begin
            errors++;
            $display("FAIL pp_same_edge got lvl=%0d en=%0b addr=%h wd=%h want 2 1 300 a0",
                     fifo_level, ram_en, ram_addr, ram_wdata);
        end
        for (int i = 1; i < 3; i++) begin
            tick();
            checks++;
            if ({fifo_level, ram_en, ram_addr, ram_wdata} !== {3'(2 - i), 1'b1, 12'(12'h300 + i), 8'(8'hA0 + i)}) begin
                errors++;
                $display("FAIL pp_drain i=%0d got lvl=%0d en=%0b addr=%h wd=%h want %0d 1 %h %h",
                         i, fifo_level, ram_en, ram_addr, ram_wdata, 2 - i, 12'(12'h300 + i), 8'(8'hA0 + i));
            end
        end
        tick();
        checks++;
        if (ram_en !== 1'b0) begin
            errors++;
            $display("FAIL pp_no_dup got en=%0b want 0", ram_en);
        end
    endtask

    task automatic test_blank_write();
        do_reset();
        blank = 1'b0;
        host_valid = 1'b1; host_we = 1'b1; host_addr = 12'h400; host_wdata = 8'h77;
        tick();
        host_valid = 1'b0;
        tick();
`ifdef VRAM_BLANK_WRITE_EN
        checks++;
        if ({ram_en, ram_we, fifo_level} !== {1'b0, 1'b0, 3'd1}) begin
            errors++;
            $display("FAIL blank_hold got en=%0b we=%0b lvl=%0d want 0 0 1", ram_en, ram_we, fifo_level);
        end
        blank = 1'b1;
        tick();
`endif
        checks++;
        if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 12'h400, 8'h77}) begin
            errors++;
            $display("FAIL blank_issue got en=%0b we=%0b addr=%h wd=%h want 1 1 400 77",
                     ram_en, ram_we, ram_addr, ram_wdata);
        end
        blank = 1'b0;
        host_valid = 1'b1; host_we = 1'b0; host_addr = 12'h400; host_wdata = 8'h00;
        tick();
        host_valid = 1'b0;
        tick();
        checks++;
        if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 12'h400}) begin
            errors++;
            $display("FAIL blank_read_issue got en=%0b we=%0b addr=%h want 1 0 400", ram_en, ram_we, ram_addr);
        end
        tick();
        checks++;
        if ({host_rvalid, host_rdata} !== {1'b1, 8'h77}) begin
            errors++;
            $display("FAIL blank_read_data got rv=%0b rd=%h want 1 77", host_rvalid, host_rdata);
        end
        blank = 1'b1;
    endtask

    task automatic test_reset_inflight();
        do_reset();
        disp_req = 1'b1; disp_addr = 12'h0F0;
        host_valid = 1'b1; host_we = 1'b0; host_addr = 12'h010; host_wdata = 8'h00;
        tick();
        host_we = 1'b1; host_addr = 12'h500; host_wdata = 8'h33;
        tick();
        disp_req = 1'b0; host_valid = 1'b0;
        tick();
        checks++;
        if ({ram_en, ram_we, ram_addr, fifo_level, stall_count} !== {1'b1, 1'b0, 12'h010, 3'd1, 16'd1}) begin
            errors++;
            $display("FAIL inflight_pre got en=%0b we=%0b addr=%h lvl=%0d stall=%0d want 1 0 010 1 1",
                     ram_en, ram_we, ram_addr, fifo_level, stall_count);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({host_rvalid, disp_rvalid, ram_en, fifo_level, stall_count} !== 21'd0) begin
            errors++;
            $display("FAIL inflight_async got hrv=%0b drv=%0b en=%0b lvl=%0d stall=%0d want all zero",
                     host_rvalid, disp_rvalid, ram_en, fifo_level, stall_count);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({host_rvalid, host_rdata} !== 9'd0) begin
                errors++;
                $display("FAIL inflight_no_rvalid i=%0d got rv=%0b rd=%h want 0 00", i, host_rvalid, host_rdata);
            end
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({ram_en, host_rvalid, fifo_level, host_ready} !== {1'b0, 1'b0, 3'd0, 1'b1}) begin
                errors++;
                $display("FAIL inflight_discard i=%0d got en=%0b hrv=%0b lvl=%0d ready=%0b want 0 0 0 1",
                         i, ram_en, host_rvalid, fifo_level, host_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_disp_priority();
        test_drain();
        test_push_pop();
        test_blank_write();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
